// File: rtl/i2c_target_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_ctrl
// Purpose  : I2C target (slave) byte engine. Answers to one 7-bit address,
//            delivers written bytes through a one-entry rx buffer and returns
//            read bytes from a tx valid/ready source. SDA is open drain.
// Ports    : clk_i, rst_i            - system clock, sync active-high reset
//            scl_i, sda_i            - raw bus lines (synchronized inside)
//            sda_oe_o                - 1 pulls SDA low, 0 releases it
//            rx_data_o/valid/ready   - received write byte, held until taken
//            tx_data_i/valid/ready   - read byte source, ready is a pulse
//            start_o, stop_o         - one-cycle bus condition pulses
//            rw_o                    - R/W bit of current addressed transfer
//            busy_o                  - high from START through STOP
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_ctrl #(
  parameter logic [6:0] SLV_ADDR    = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       rw_o,
  output logic       busy_o
);

  // Depth below 2 is not metastability safe, so clamp it.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WR_DATA   = 3'd3;
  localparam logic [2:0] S_WR_ACK    = 3'd4;
  localparam logic [2:0] S_RD_DATA   = 3'd5;
  localparam logic [2:0] S_RD_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  // --------------------------------------------------------------------------
  // Synchronizers plus one history flop for edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_N-1:0] scl_sync;
  logic [SYNC_N-1:0] sda_sync;
  logic              scl_hist;
  logic              sda_hist;
  logic              scl_s;
  logic              sda_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_N-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_N-2:0], sda_i};
      scl_hist <= scl_sync[SYNC_N-1];
      sda_hist <= sda_sync[SYNC_N-1];
    end
  end

  assign scl_s = scl_sync[SYNC_N-1];
  assign sda_s = sda_sync[SYNC_N-1];

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s & scl_hist;
  // SCL must be high on both samples, so SDA moving while SCL is low (or on
  // the same cycle SCL moves) is never taken as a bus condition.
  assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

  // --------------------------------------------------------------------------
  // Datapath registers referenced by the FSM
  // --------------------------------------------------------------------------
  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       addr_hit;
  logic       wr_accept;
  logic       mack;
  logic [7:0] byte_in;
  logic [7:0] tx_byte;
  logic       byte_end;

  assign byte_in  = {shreg[6:0], sda_s};
  assign tx_byte  = tx_valid_i ? tx_data_i : 8'hFF;
  assign byte_end = (bit_cnt == 4'd8);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = S_IDLE;
    end else if (start_det) begin
      state_nxt = S_ADDR;
    end else if (scl_fall) begin
      case (state)
        S_ADDR:     if (byte_end) state_nxt = addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: state_nxt = rw_o ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA:  if (byte_end) state_nxt = wr_accept ? S_WR_ACK : S_WAIT_STOP;
        S_WR_ACK:   state_nxt = S_WR_DATA;
        S_RD_DATA:  if (byte_end) state_nxt = S_RD_ACK;
        S_RD_ACK:   state_nxt = mack ? S_WAIT_STOP : S_RD_DATA;
        default:    state_nxt = state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (datapath strobes and next SDA drive)
  // --------------------------------------------------------------------------
  logic cnt_clr;
  logic cnt_inc;
  logic shift_in;
  logic addr_done;
  logic wr_done;
  logic rx_free;
  logic store_rx;
  logic tx_load;
  logic rd_shift;
  logic mack_smp;
  logic sda_oe_nxt;

  always_comb begin
    cnt_clr    = start_det;
    cnt_inc    = 1'b0;
    shift_in   = 1'b0;
    addr_done  = 1'b0;
    wr_done    = 1'b0;
    rx_free    = ~rx_valid_o | rx_ready_i;
    store_rx   = 1'b0;
    tx_load    = 1'b0;
    rd_shift   = 1'b0;
    mack_smp   = 1'b0;
    sda_oe_nxt = sda_oe_o;

    case (state)
      S_ADDR, S_WR_DATA: begin
        if (scl_rise && !byte_end) begin
          cnt_inc  = 1'b1;
          shift_in = 1'b1;
        end
        addr_done = scl_rise && (state == S_ADDR) && (bit_cnt == 4'd7);
        wr_done   = scl_rise && (state == S_WR_DATA) && (bit_cnt == 4'd7);
        store_rx  = wr_done && rx_free;
        if (scl_fall && byte_end)
          sda_oe_nxt = (state == S_ADDR) ? addr_hit : wr_accept;
      end
      S_ADDR_ACK: begin
        if (scl_fall) begin
          cnt_clr    = 1'b1;
          tx_load    = rw_o;
          sda_oe_nxt = rw_o ? ~tx_byte[7] : 1'b0;
        end
      end
      S_WR_ACK: begin
        if (scl_fall) begin
          cnt_clr    = 1'b1;
          sda_oe_nxt = 1'b0;
        end
      end
      S_RD_DATA: begin
        cnt_inc = scl_rise && !byte_end;
        if (scl_fall) begin
          // shreg[7] always holds the next bit to put on the bus
          rd_shift   = !byte_end;
          sda_oe_nxt = byte_end ? 1'b0 : ~shreg[7];
        end
      end
      S_RD_ACK: begin
        mack_smp = scl_rise;
        if (scl_fall) begin
          cnt_clr    = 1'b1;
          tx_load    = ~mack;
          sda_oe_nxt = mack ? 1'b0 : ~tx_byte[7];
        end
      end
      default: sda_oe_nxt = 1'b0;
    endcase

    if (start_det || stop_det) sda_oe_nxt = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      addr_hit   <= 1'b0;
      wr_accept  <= 1'b0;
      mack       <= 1'b1;
      sda_oe_o   <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rw_o       <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if (cnt_clr)      bit_cnt <= 4'd0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;

      if (shift_in)      shreg <= byte_in;
      else if (tx_load)  shreg <= {tx_byte[6:0], 1'b1};
      else if (rd_shift) shreg <= {shreg[6:0], 1'b1};

      if (addr_done) begin
        addr_hit <= (byte_in[7:1] == SLV_ADDR);
        if (byte_in[7:1] == SLV_ADDR) rw_o <= byte_in[0];
      end

      if (wr_done)  wr_accept <= rx_free;
      if (mack_smp) mack      <= sda_s;

      sda_oe_o <= sda_oe_nxt;

      // A new byte wins over the clear so a same-cycle handoff is not lost.
      if (store_rx) begin
        rx_data_o  <= byte_in;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      tx_ready_o <= tx_load & tx_valid_i;
      start_o    <= start_det;
      stop_o     <= stop_det;

      // Cleared on the stop_o cycle so busy_o covers the STOP pulse itself.
      if (start_det)   busy_o <= 1'b1;
      else if (stop_o) busy_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_ctrl
// Purpose  : Self-checking bench for i2c_target_ctrl. A bit-banged I2C master
//            drives the bus; a table of write transactions is applied in a
//            loop, followed by hand-written read / repeated START / reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_ctrl;

  localparam int QC = 8;  // clock cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       start_p;
  logic       stop_p;
  logic       rw;
  logic       busy;

  always #5 clk = ~clk;

  // open-drain wired-AND of master and target
  assign sda_line = m_sda & ~sda_oe;

  i2c_target_ctrl #(.SLV_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (m_scl),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .start_o    (start_p),
    .stop_o     (stop_p),
    .rw_o       (rw),
    .busy_o     (busy)
  );

  // ---------------- event monitor (posedge; the test works on negedge) ------
  int   n_start = 0, n_stop = 0, n_txr = 0, n_rxv = 0, n_idle = 0, n_stopbusy = 0;
  logic rxv_q = 1'b0;

  always @(posedge clk) begin
    if (start_p)          n_start    <= n_start + 1;
    if (stop_p)           n_stop     <= n_stop + 1;
    if (stop_p && busy)   n_stopbusy <= n_stopbusy + 1;
    if (tx_ready)         n_txr      <= n_txr + 1;
    if (rx_valid && !rxv_q) n_rxv    <= n_rxv + 1;
    if (!busy)            n_idle     <= n_idle + 1;
    rxv_q <= rx_valid;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus master ----------------
  task automatic wq();
    repeat (QC) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic rep_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq(); wq();
  endtask

  task automatic bit_xfer(input logic drive, output logic rd);
    m_sda = drive; wq();
    m_scl = 1'b1;  wq();
    rd = sda_line; wq();
    m_scl = 1'b0;  wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, d);
      b[i] = d;
    end
    bit_xfer(mack, d);
  endtask

  // ---------------- write transaction table ----------------
  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       exp_aack;   // 0 = ACK
    logic       exp_dack;
    logic [7:0] exp_rx;
    int         exp_rxp;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic       a, d;
    logic [7:0] r1, r2, r3;
    int b_start, b_stop, b_txr, b_rxv, b_idle, b_sb;

    vt[0] = '{8'h44, 8'hA5, 1'b0, 1'b0, 8'hA5, 1};  // 0x22+W, accepted
    vt[1] = '{8'h46, 8'h5A, 1'b1, 1'b1, 8'hA5, 0};  // 0x23+W, ignored
    vt[2] = '{8'h44, 8'h00, 1'b0, 1'b0, 8'h00, 1};
    vt[3] = '{8'h44, 8'hFF, 1'b0, 1'b0, 8'hFF, 1};
    vt[4] = '{8'h22, 8'h33, 1'b1, 1'b1, 8'hFF, 0};  // 0x11+W, ignored

    // ---- reset state ----
    repeat (4) @(negedge clk);
    check("reset outputs",
          {24'd0, sda_oe, rx_valid, tx_ready, start_p, stop_p, rw, busy, 1'b0}, 32'd0);
    check("reset rx_data", {24'd0, rx_data}, 32'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ---- table-driven writes ----
    for (int i = 0; i < 5; i++) begin
      b_start = n_start; b_stop = n_stop; b_rxv = n_rxv; b_sb = n_stopbusy;
      bus_start();
      write_byte(vt[i].addr_byte, a);
      write_byte(vt[i].data, d);
      check($sformatf("v%0d busy mid", i), {31'd0, busy}, 32'd1);
      bus_stop();
      wq();
      check($sformatf("v%0d addr ack", i), {31'd0, a}, {31'd0, vt[i].exp_aack});
      check($sformatf("v%0d data ack", i), {31'd0, d}, {31'd0, vt[i].exp_dack});
      check($sformatf("v%0d rx_data", i), {24'd0, rx_data}, {24'd0, vt[i].exp_rx});
      check($sformatf("v%0d rx_valid pulses", i), n_rxv - b_rxv, vt[i].exp_rxp);
      check($sformatf("v%0d start cycles", i), n_start - b_start, 1);
      check($sformatf("v%0d stop cycles", i), n_stop - b_stop, 1);
      check($sformatf("v%0d busy at stop", i), n_stopbusy - b_sb, 1);
      check($sformatf("v%0d busy after", i), {31'd0, busy}, 32'd0);
    end

    // ---- rx buffer full: second byte NACKed and dropped ----
    rx_ready = 1'b0;
    bus_start();
    write_byte(8'h44, a); check("full addr ack", {31'd0, a}, 32'd0);
    write_byte(8'h11, d); check("full 1st ack", {31'd0, d}, 32'd0);
    write_byte(8'h22, d); check("full 2nd nack", {31'd0, d}, 32'd1);
    bus_stop();
    wq();
    check("full rx_valid held", {31'd0, rx_valid}, 32'd1);
    check("full rx_data", {24'd0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("full rx_valid cleared", {31'd0, rx_valid}, 32'd0);

    // ---- read: ACK then NACK ----
    tx_valid = 1'b1; tx_data = 8'h3C;
    b_txr = n_txr;
    bus_start();
    write_byte(8'h45, a); check("rd addr ack", {31'd0, a}, 32'd0);
    tx_data = 8'hC3;
    read_byte(1'b0, r1);
    read_byte(1'b1, r2);
    check("rd byte0", {24'd0, r1}, 32'h3C);
    check("rd byte1", {24'd0, r2}, 32'hC3);
    check("rd sda released after nack", {31'd0, sda_oe}, 32'd0);
    read_byte(1'b1, r3);
    check("rd after nack", {24'd0, r3}, 32'hFF);
    check("rd rw_o", {31'd0, rw}, 32'd1);
    bus_stop();
    wq();
    check("rd tx_ready pulses", n_txr - b_txr, 2);

    // ---- write, repeated START, read with no tx data ----
    tx_valid = 1'b0;
    b_start = n_start; b_stop = n_stop; b_txr = n_txr;
    bus_start();
    b_idle = n_idle;
    write_byte(8'h44, a); check("rs addr W ack", {31'd0, a}, 32'd0);
    write_byte(8'h5A, d); check("rs data ack", {31'd0, d}, 32'd0);
    rep_start();
    write_byte(8'h45, a); check("rs addr R ack", {31'd0, a}, 32'd0);
    check("rs rw_o", {31'd0, rw}, 32'd1);
    read_byte(1'b1, r1);
    check("rs read empty", {24'd0, r1}, 32'hFF);
    check("rs busy throughout", n_idle - b_idle, 0);
    bus_stop();
    wq();
    check("rs start cycles", n_start - b_start, 2);
    check("rs stop cycles", n_stop - b_stop, 1);
    check("rs tx_ready pulses", n_txr - b_txr, 0);
    check("rs rx_data", {24'd0, rx_data}, 32'h5A);

    // ---- reset during 5th bit of a read ----
    tx_valid = 1'b1; tx_data = 8'h00;
    bus_start();
    write_byte(8'h45, a); check("rst addr ack", {31'd0, a}, 32'd0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, d);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    check("rst bit5 driven", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst sda released", {31'd0, sda_oe}, 32'd0);
    m_scl = 1'b0; wq();
    rst = 1'b0; wq();
    check("rst busy", {31'd0, busy}, 32'd0);
    tx_valid = 1'b0;
    bus_start();
    write_byte(8'h44, a); check("post-rst addr ack", {31'd0, a}, 32'd0);
    write_byte(8'h77, d); check("post-rst data ack", {31'd0, d}, 32'd0);
    bus_stop();
    wq();
    check("post-rst rx_data", {24'd0, rx_data}, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
